// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary to packed BCD converter.
// One add-3/shift step per clock. The result is held on out_digits/out_ovf
// until the next result-load edge, so the display stays steady while the
// following conversion runs.
module bin2bcd_seq #(
  parameter int IN_W       = 32,
  parameter int OUT_DIGITS = 8,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_num,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*OUT_DIGITS-1:0] out_digits,
  output logic                    out_ovf,
  output logic                    busy
);

  // Enough internal digits that no intermediate value is ever truncated
  localparam int NBCD = (IN_W * 77) / 256 + 1;
  localparam int BW   = 4 * NBCD;
  localparam int OW   = 4 * OUT_DIGITS;
  localparam int CW   = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IN_W-1:0] bin_q;
  logic [IN_W-1:0] bin_nxt;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_nxt;
  logic [CW-1:0]   cnt_q;
  logic            last_step;
  logic [OW-1:0]   res_lo;
  logic            res_ovf;
  logic [OW-1:0]   res_digits;
  logic [OW-1:0]   digits_q;
  logic            ovf_q;

  assign last_step = (cnt_q == CW'(IN_W - 1));

  // One double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt = {bcd_adj[BW-2:0], bin_q[IN_W-1]};
    bin_nxt = {bin_q[IN_W-2:0], 1'b0};
  end

  // Split the finished BCD value into displayed digits and overflow indication
  generate
    if (NBCD > OUT_DIGITS) begin : g_ovf
      assign res_lo  = bcd_nxt[OW-1:0];
      assign res_ovf = |bcd_nxt[BW-1:OW];
    end else begin : g_fit
      assign res_lo  = OW'(bcd_nxt);
      assign res_ovf = 1'b0;
    end
  endgenerate

  assign res_digits = ((SATURATE != 0) && res_ovf) ? {OUT_DIGITS{4'h9}} : res_lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, step through CONV, hold in OUT until consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = CONV;
      CONV: if (last_step) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operand, iterate, and capture the result on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q <= in_num;
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        CONV: begin
          bin_q <= bin_nxt;
          bcd_q <= bcd_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            digits_q <= res_digits;
            ovf_q    <= res_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == CONV);
  assign out_valid  = (state_q == OUT);
  assign out_digits = digits_q;
  assign out_ovf    = ovf_q;

endmodule
